vga_rect_gen: RTL and testbench

Pixel-colour source feeding `vga_module` in the vga_rectangle design. Takes the current pixel coordinate and active-video flag from the VGA timing stage and returns a registered 8-bit 3-3-2 colour. A filled rectangle is drawn over a background colour. Once per frame the rectangle moves diagonally and bounces off the screen edges.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_rect_gen_bounce_axis.sv | 66 ++++++
 rtl/vga_rect_gen.sv | 87 ++++++++
 tb/tb_vga_rect_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared colour type, coordinate width, palette and default geometry for the rectangle generator.
package vga_pkg;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_RECT_W   = 64;
    localparam int DEF_RECT_H   = 48;
    localparam int DEF_STEP     = 2;

    // Entry 0 sits in the low byte.
    localparam logic [63:0] PALETTE = {8'h92, 8'hFF, 8'hE3, 8'h03, 8'h1F, 8'h1C, 8'hFC, 8'hE0};

    function automatic logic [7:0] pal_color(input logic [2:0] idx);
        return PALETTE[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/vga_rect_gen_bounce_axis.sv
// bounce_axis: one axis of rectangle motion; steps once per tick and reflects off 0 and EXTENT-SIZE.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int EXTENT = DEF_H_ACTIVE,
    parameter int SIZE   = DEF_RECT_W,
    parameter int STEP   = DEF_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_i,
    output logic [COORD_W-1:0] pos_o,
    output logic               dir_o,
    output logic               hit_o
);

    localparam logic [COORD_W:0]   LIMIT   = (COORD_W+1)'(EXTENT - SIZE);
    localparam logic [COORD_W:0]   STEP_W  = (COORD_W+1)'(STEP);
    localparam logic [COORD_W-1:0] STEP_N  = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] LIMIT_N = COORD_W'(EXTENT - SIZE);

    logic [COORD_W-1:0] pos_q, pos_d;
    logic               dir_q, dir_d;
    logic [COORD_W:0]   pos_ext;

    assign pos_ext = {1'b0, pos_q};

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        hit_o = 1'b0;
        if (tick_i) begin
            if (!dir_q) begin
                if (pos_ext + STEP_W >= LIMIT) begin
                    pos_d = LIMIT_N;
                    dir_d = 1'b1;
                    hit_o = 1'b1;
                end else begin
                    pos_d = pos_q + STEP_N;
                end
            end else begin
                if (pos_ext <= STEP_W) begin
                    pos_d = '0;
                    dir_d = 1'b0;
                    hit_o = 1'b1;
                end else begin
                    pos_d = pos_q - STEP_N;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            dir_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o = pos_q;
    assign dir_o = dir_q;

endmodule

// File: rtl/vga_rect_gen.sv
// vga_rect_gen: registered 3-3-2 colour for a bouncing filled rectangle over a background.
// Define RECT_COLOR_CYCLE_EN to step the rectangle colour through a palette on every wall hit.
module vga_rect_gen
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = DEF_H_ACTIVE,
    parameter int          V_ACTIVE = DEF_V_ACTIVE,
    parameter int          RECT_W   = DEF_RECT_W,
    parameter int          RECT_H   = DEF_RECT_H,
    parameter int          STEP     = DEF_STEP,
    parameter logic [7:0]  FG_COLOR = 8'hE0,
    parameter logic [7:0]  BG_COLOR = 8'h03
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               video_on,
    input  logic               frame_tick,
    input  logic               pause,
    output logic [2:0]         rgb_r,
    output logic [2:0]         rgb_g,
    output logic [1:0]         rgb_b,
    output logic               de_out,
    output logic [COORD_W-1:0] rect_x,
    output logic [COORD_W-1:0] rect_y,
    output logic [7:0]         bounce_cnt
);

    logic       tick, hit_x, hit_y, hit, dir_x, dir_y, unused_dir;
    logic       in_rect, de_q;
    logic [7:0] fg, cnt_q, cnt_d;
    rgb332_t    color_q, color_d;

    assign tick       = frame_tick & ~pause;
    assign hit        = hit_x | hit_y;
    assign unused_dir = dir_x ^ dir_y;

    bounce_axis #(.EXTENT(H_ACTIVE), .SIZE(RECT_W), .STEP(STEP)) u_axis_x (
        .clk(sys_clk), .rst_n(rst_n), .tick_i(tick), .pos_o(rect_x), .dir_o(dir_x), .hit_o(hit_x)
    );

    bounce_axis #(.EXTENT(V_ACTIVE), .SIZE(RECT_H), .STEP(STEP)) u_axis_y (
        .clk(sys_clk), .rst_n(rst_n), .tick_i(tick), .pos_o(rect_y), .dir_o(dir_y), .hit_o(hit_y)
    );

    // 11-bit compares so rect+size never wraps past 1023.
    assign in_rect = ({1'b0, pixel_x} >= {1'b0, rect_x}) &&
                     ({1'b0, pixel_x} <  {1'b0, rect_x} + (COORD_W+1)'(RECT_W)) &&
                     ({1'b0, pixel_y} >= {1'b0, rect_y}) &&
                     ({1'b0, pixel_y} <  {1'b0, rect_y} + (COORD_W+1)'(RECT_H));

`ifdef RECT_COLOR_CYCLE_EN
    logic [2:0] pal_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) pal_q <= '0;
        else if (hit) pal_q <= pal_q + 3'd1;
    end

    assign fg = pal_color(pal_q);
`else
    assign fg = FG_COLOR;
`endif

    assign color_d = !video_on ? rgb332_t'(8'h00) : in_rect ? rgb332_t'(fg) : rgb332_t'(BG_COLOR);
    assign cnt_d   = (hit && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= '0;
            de_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            color_q <= color_d;
            de_q    <= video_on;
            cnt_q   <= cnt_d;
        end
    end

    assign rgb_r      = color_q.r;
    assign rgb_g      = color_q.g;
    assign rgb_b      = color_q.b;
    assign de_out     = de_q;
    assign bounce_cnt = cnt_q;

endmodule

// File: tb/tb_vga_rect_gen.sv
// tb_vga_rect_gen: vector table, hand sequences and randomized traffic against a position/colour model.
module tb_vga_rect_gen;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [9:0] px[2], py[2];
    logic       von[2], ft[2], pz[2];
    logic [2:0] rr[2], gg[2];
    logic [1:0] bb[2];
    logic       de[2];
    logic [9:0] rx[2], ry[2];
    logic [7:0] bc[2];

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    vga_rect_gen u_dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .pixel_x(px[0]), .pixel_y(py[0]), .video_on(von[0]),
        .frame_tick(ft[0]), .pause(pz[0]), .rgb_r(rr[0]), .rgb_g(gg[0]), .rgb_b(bb[0]),
        .de_out(de[0]), .rect_x(rx[0]), .rect_y(ry[0]), .bounce_cnt(bc[0])
    );

    vga_rect_gen #(.H_ACTIVE(20), .V_ACTIVE(20), .RECT_W(4), .RECT_H(4), .STEP(2)) u_small (
        .sys_clk(sys_clk), .rst_n(rst_n), .pixel_x(px[1]), .pixel_y(py[1]), .video_on(von[1]),
        .frame_tick(ft[1]), .pause(pz[1]), .rgb_r(rr[1]), .rgb_g(gg[1]), .rgb_b(bb[1]),
        .de_out(de[1]), .rect_x(rx[1]), .rect_y(ry[1]), .bounce_cnt(bc[1])
    );

    int ext_w[2] = '{640, 20};
    int ext_h[2] = '{480, 20};
    int rw[2]    = '{64, 4};
    int rh[2]    = '{48, 4};
    int mx[2], my[2], mdx[2], mdy[2], mcnt[2], mpal[2];
    logic [7:0] pal[8] = '{8'hE0, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'hE3, 8'hFF, 8'h92};

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       v;
        logic [7:0] col;
        logic       de;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic logic [7:0] fg_of(input int i);
`ifdef RECT_COLOR_CYCLE_EN
        return pal[mpal[i]];
`else
        return (i >= 0) ? 8'hE0 : 8'hE0;
`endif
    endfunction

    function automatic logic [7:0] exp_col(input int i, input int x, input int y, input bit v);
        if (!v) return 8'h00;
        if (x >= mx[i] && x < mx[i] + rw[i] && y >= my[i] && y < my[i] + rh[i]) return fg_of(i);
        return 8'h03;
    endfunction

    task automatic axis(inout int p, inout int d, input int lim, output bit h);
        h = 0;
        if (d == 0) begin
            if (p + 2 >= lim) begin p = lim; d = 1; h = 1; end
            else p = p + 2;
        end else begin
            if (p <= 2) begin p = 0; d = 0; h = 1; end
            else p = p - 2;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; mcnt[i] = 0; mpal[i] = 0;
        end
    endtask

    task automatic cycle(input int i, input int x, input int y, input bit v, input bit t, input bit p);
        logic [7:0] ec;
        int a, d;
        bit hx, hy;
        px[i] = 10'(x); py[i] = 10'(y); von[i] = v; ft[i] = t; pz[i] = p;
        ec = exp_col(i, x, y, v);
        if (t && !p) begin
            a = mx[i]; d = mdx[i]; axis(a, d, ext_w[i] - rw[i], hx); mx[i] = a; mdx[i] = d;
            a = my[i]; d = mdy[i]; axis(a, d, ext_h[i] - rh[i], hy); my[i] = a; mdy[i] = d;
            if (hx || hy) begin
                if (mcnt[i] < 255) mcnt[i]++;
                mpal[i] = (mpal[i] + 1) % 8;
            end
        end
        @(posedge sys_clk);
        #1;
        ft[i] = 1'b0;
        chk($sformatf("u%0d color", i), {rr[i], gg[i], bb[i]}, ec);
        chk($sformatf("u%0d de_out", i), de[i], v);
        chk($sformatf("u%0d rect_x", i), rx[i], mx[i]);
        chk($sformatf("u%0d rect_y", i), ry[i], my[i]);
        chk($sformatf("u%0d bounce_cnt", i), bc[i], mcnt[i]);
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s u%0d color", tag, i), {rr[i], gg[i], bb[i]}, 0);
            chk($sformatf("%s u%0d de_out", tag, i), de[i], 0);
            chk($sformatf("%s u%0d rect_x", tag, i), rx[i], 0);
            chk($sformatf("%s u%0d rect_y", tag, i), ry[i], 0);
            chk($sformatf("%s u%0d bounce_cnt", tag, i), bc[i], 0);
        end
    endtask

    initial begin
        tbl[0] = '{x: 10'd10,  y: 10'd10,  v: 1'b1, col: 8'hE0, de: 1'b1};
        tbl[1] = '{x: 10'd64,  y: 10'd10,  v: 1'b1, col: 8'h03, de: 1'b1};
        tbl[2] = '{x: 10'd10,  y: 10'd10,  v: 1'b0, col: 8'h00, de: 1'b0};
        tbl[3] = '{x: 10'd63,  y: 10'd47,  v: 1'b1, col: 8'hE0, de: 1'b1};
        tbl[4] = '{x: 10'd63,  y: 10'd48,  v: 1'b1, col: 8'h03, de: 1'b1};
        tbl[5] = '{x: 10'd639, y: 10'd479, v: 1'b1, col: 8'h03, de: 1'b1};
        for (int i = 0; i < 2; i++) begin
            px[i] = 10'd10; py[i] = 10'd10; von[i] = 1'b1; ft[i] = 1'b0; pz[i] = 1'b0;
        end
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            cycle(0, int'(tbl[k].x), int'(tbl[k].y), tbl[k].v, 1'b0, 1'b0);
            chk($sformatf("tbl%0d color", k), {rr[0], gg[0], bb[0]}, tbl[k].col);
            chk($sformatf("tbl%0d de_out", k), de[0], tbl[k].de);
        end

        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("paused rect_x", rx[0], 0);
        chk("paused rect_y", ry[0], 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("5 ticks rect_x", rx[0], 10);
        chk("5 ticks rect_y", ry[0], 10);
        for (int k = 5; k < 287; k++) cycle(0, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("287 ticks rect_x", rx[0], 574);
        chk("287 ticks bounce", bc[0], 1);
        cycle(0, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("right wall rect_x", rx[0], 576);
        chk("right wall bounce", bc[0], 2);
        cycle(0, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("after wall rect_x", rx[0], 574);

        for (int k = 0; k < 2500; k++)
            cycle(0, int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 1'($urandom),
                  ($urandom % 4) == 0, ($urandom % 4) == 0);

        for (int k = 0; k < 8; k++) cycle(1, int'($urandom_range(0, 19)), int'($urandom_range(0, 19)), 1'b1, 1'b1, 1'b0);
        chk("corner rect_x", rx[1], 16);
        chk("corner rect_y", ry[1], 16);
        chk("corner bounce once", bc[1], 1);
        cycle(1, 16, 16, 1'b1, 1'b0, 1'b0);
`ifdef RECT_COLOR_CYCLE_EN
        chk("first hit color", {rr[1], gg[1], bb[1]}, 8'hFC);
`else
        chk("first hit color", {rr[1], gg[1], bb[1]}, 8'hE0);
`endif
        for (int k = 0; k < 64; k++) cycle(1, int'($urandom_range(0, 19)), int'($urandom_range(0, 19)), 1'b1, 1'b1, 1'b0);
        chk("nine hits bounce", bc[1], 9);
        cycle(1, 16, 16, 1'b1, 1'b0, 1'b0);
`ifdef RECT_COLOR_CYCLE_EN
        chk("ninth hit color", {rr[1], gg[1], bb[1]}, 8'hFC);
`else
        chk("ninth hit color", {rr[1], gg[1], bb[1]}, 8'hE0);
`endif
        for (int k = 0; k < 2100; k++) cycle(1, int'($urandom_range(0, 19)), int'($urandom_range(0, 19)), 1'b1, 1'b1, 1'b0);
        chk("saturated bounce", bc[1], 255);

        @(posedge sys_clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        model_reset();
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 10, 10, 1'b1, 1'b0, 1'b0);
        chk("post reset color", {rr[0], gg[0], bb[0]}, 8'hE0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
